dac_interleave_tx: RTL and testbench
====================================

# dac_interleave_tx

Transmitter end of the interleaved two-channel DAC bus: accepts channel A/B sample pairs over a valid/ready stream, buffers them, saturates and converts to offset binary, and drives one word per clock alternately for A and B with select and write strobes. Sits between the ASG/streaming DAC path and the DAC pins, and is the counterpart of the bench's DAC bus receiver. Also sequences the DAC reset and reports underruns.

## Interface
- DW_IN, 16: signed input sample width.
- DW, 14: DAC word width.
- FIFO_AW, 3: pair-FIFO address width; depth 2**FIFO_AW.
- START_LVL, 4: FIFO level required to leave START.
- RST_CYC, 16: cycles dac_rst_o stays high after reset release.

Ports (one clock; reset is asynchronous and active-high):
- dac_clk_i  in  1  block clock
- dac_rst_i  in  1  asynchronous active-high reset
- en_i  in  1  run enable
- clr_i  in  1  clears underrun_o and underrun_cnt_o
- s_dat_a_i  in  DW_IN  channel A sample, signed
- s_dat_b_i  in  DW_IN  channel B sample, signed
- s_valid_i  in  1  pair valid
- s_ready_o  out  1  pair accepted when valid & ready
- dac_dat_o  out  DW  DAC word, offset binary
- dac_sel_o  out  1  1 = word is channel A
- dac_wrt_o  out  1  high on channel-B cycle, latches the pair
- dac_rst_o  out  1  DAC reset
- underrun_o  out  1  sticky underrun flag
- underrun_cnt_o  out  16  saturating underrun-pair count
- state_o  out  2  IDLE=0, START=1, RUN=2, UNDER=3
- fifo_lvl_o  out  FIFO_AW+1  FIFO occupancy

## Operation
- Reset values: dac_dat_o=midscale (2**(DW-1), 14'h2000), dac_sel_o=0, dac_wrt_o=0, dac_rst_o=1, s_ready_o=0, underrun_o=0, underrun_cnt_o=0, state IDLE, FIFO empty.
- dac_rst_o drops after RST_CYC cycles of released reset; s_ready_o = ~dac_rst_o & ~full. Push blocked when full even if a pop occurs the same cycle.
- Conversion per channel at FIFO output: clamp to [-2**(DW-1), 2**(DW-1)-1], then word = {~sat[DW-1], sat[DW-2:0]}.
- States:
  - IDLE: outputs midscale, sel=0, wrt=0; FIFO accepts pushes. en_i=1 -> START.
  - START: wait until fifo_lvl_o >= START_LVL -> pop, RUN. en_i=0 -> IDLE.
  - RUN: 2-cycle pair frame; phase 0 drives A (sel=1, wrt=0), phase 1 drives B (sel=0, wrt=1). At end of phase 1: FIFO non-empty -> pop next pair; empty -> UNDER.
  - UNDER: replays last held pair with the same framing; each replayed pair increments underrun_cnt_o (saturating at 16'hFFFF) and sets underrun_o. At end of phase 1 with FIFO non-empty -> pop, RUN.
- en_i=0 during RUN/UNDER: current pair completes, then IDLE; FIFO flushed on entry to IDLE.
- clr_i and a new underrun in the same cycle: set wins, counter = 1.

## Timing
- Pop on the edge ending START or phase 1; A appears on dac_dat_o the next cycle, B the cycle after.
- First A word: 2 cycles after the push that reaches START_LVL (level registered, pop, output).
- dac_wrt_o is high exactly one cycle in two while RUN/UNDER; never high in IDLE/START.
- Return to IDLE: midscale on dac_dat_o in the cycle after the last B word.
- Reset asserted mid-frame: all outputs return to reset values immediately (async); FIFO contents discarded.

## Structure
- Package dac_tx_pkg: state enum, midscale constant, saturate-and-offset function (parameterized by DW_IN/DW).
- Sub-module dac_tx_fifo: synchronous FIFO, width 2*DW_IN, depth 2**FIFO_AW, level output. FSM, phase toggle, reset sequencer and counters live in the top.

## Test plan
- Reset release -> dac_rst_o high for 16 cycles, s_ready_o low; then ready=1, dac_dat_o=0x2000.
- en_i=1, push pairs (A=0,B=-8192),(A=8191,B=20000),(A=-30000,B=1),(A=100,B=-100) -> dac_dat_o sequence 0x2000,0x0000,0x3FFF,0x3FFF,0x0000,0x2001,0x2064,0x1F9C; sel 1,0 alternating; wrt on B cycles.
- Stop pushing after 4 pairs -> UNDER; last pair (0x2064/0x1F9C) repeats, underrun_o=1, cnt increments per pair; push resumes -> RUN with new pair on next frame boundary.
- Push 8 pairs in IDLE with en_i=0 -> s_ready_o=0 at level 8; extra valid stalls; en_i then 1 -> drain in order.
- en_i=0 during phase 0 -> B word still output with wrt=1, then midscale, fifo_lvl_o=0.
- clr_i pulse coinciding with underrun -> underrun_o stays 1, underrun_cnt_o=1.

Source files
------------

// File: rtl/dac_tx_pkg.sv
// Shared types and sample conversion helpers for the interleaved DAC transmitter.
package dac_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        UNDER = 2'd3
    } state_t;

    localparam int DW_IN_DEF = 16;
    localparam int DW_DEF    = 14;

    function automatic logic [31:0] midscale(input int dw);
        return 32'd1 << (dw - 1);
    endfunction

    // Clamp to the dw-bit two's complement range, then flip the MSB to get offset binary.
    function automatic logic [31:0] sat_offset(
        input logic signed [31:0] x,
        input int                 dw
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] s;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dw - 1));
        if (x > hi) begin
            s = hi;
        end else if (x < lo) begin
            s = lo;
        end else begin
            s = x;
        end
        return s ^ (32'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/dac_tx_fifo.sv
// Show-ahead synchronous FIFO holding A/B sample pairs, with level and flush.
module dac_tx_fifo #(
    parameter int W  = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [AW:0]   lvl,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;

    assign full  = (lvl == (AW + 1)'(DEPTH));
    assign empty = (lvl == '0);
    assign wr    = push & ~full & ~flush;
    assign rd    = pop & ~empty & ~flush;
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            lvl  <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (rd) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr, rd})
                2'b10:   lvl <= lvl + 1'b1;
                2'b01:   lvl <= lvl - 1'b1;
                default: lvl <= lvl;
            endcase
        end
    end

endmodule

// File: rtl/dac_interleave_tx.sv
// Interleaved two-channel DAC bus transmitter: pair FIFO, A/B framing,
// DAC reset sequencing and underrun replay/accounting.
module dac_interleave_tx
    import dac_tx_pkg::*;
#(
    parameter int DW_IN     = 16,
    parameter int DW        = 14,
    parameter int FIFO_AW   = 3,
    parameter int START_LVL = 4,
    parameter int RST_CYC   = 16
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [DW_IN-1:0]     s_dat_a_i,
    input  logic [DW_IN-1:0]     s_dat_b_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [DW-1:0]        dac_dat_o,
    output logic                 dac_sel_o,
    output logic                 dac_wrt_o,
    output logic                 dac_rst_o,
    output logic                 underrun_o,
    output logic [15:0]          underrun_cnt_o,
    output logic [1:0]           state_o,
    output logic [FIFO_AW:0]     fifo_lvl_o
);

    localparam int FW  = 2 * DW_IN;
    localparam int RCW = $clog2(RST_CYC + 1);
    localparam logic [DW-1:0] MID = DW'(midscale(DW));

    state_t                   state;
    logic                     phase;
    logic                     stop_req;
    logic [DW-1:0]            hold_a;
    logic [DW-1:0]            hold_b;
    logic [RCW-1:0]           rst_cnt;

    logic                     push;
    logic                     pop;
    logic                     flush;
    logic                     full;
    logic                     empty;
    logic [FW-1:0]            fdout;
    logic signed [DW_IN-1:0]  fa;
    logic signed [DW_IN-1:0]  fb;
    logic [DW-1:0]            wa;
    logic [DW-1:0]            wb;

    logic                     frame_end;
    logic                     stop;
    logic                     lvl_ok;
    logic                     under_ev;

    // DAC reset held for RST_CYC cycles after the block reset is released.
    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            rst_cnt   <= '0;
            dac_rst_o <= 1'b1;
        end else if (dac_rst_o) begin
            if (rst_cnt == RCW'(RST_CYC - 1)) begin
                dac_rst_o <= 1'b0;
            end
            rst_cnt <= rst_cnt + 1'b1;
        end
    end

    assign s_ready_o = ~dac_rst_o & ~full;
    assign push      = s_valid_i & s_ready_o;

    dac_tx_fifo #(
        .W  (FW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (dac_clk_i),
        .rst   (dac_rst_i),
        .flush (flush),
        .push  (push),
        .din   ({s_dat_a_i, s_dat_b_i}),
        .pop   (pop),
        .dout  (fdout),
        .lvl   (fifo_lvl_o),
        .full  (full),
        .empty (empty)
    );

    assign fa = fdout[FW-1:DW_IN];
    assign fb = fdout[DW_IN-1:0];
    assign wa = DW'(sat_offset(32'(fa), DW));
    assign wb = DW'(sat_offset(32'(fb), DW));

    assign frame_end = ((state == RUN) || (state == UNDER)) && phase;
    assign stop      = stop_req | ~en_i;
    assign lvl_ok    = (fifo_lvl_o >= (FIFO_AW + 1)'(START_LVL));
    assign under_ev  = frame_end & ~stop & empty;

    assign pop = ((state == START) && en_i && lvl_ok)
               || (frame_end && !stop && !empty);

    assign flush = (frame_end && stop)
                 || ((state == START) && !en_i);

    assign state_o = state;

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state     <= IDLE;
            phase     <= 1'b0;
            stop_req  <= 1'b0;
            hold_a    <= MID;
            hold_b    <= MID;
            dac_dat_o <= MID;
            dac_sel_o <= 1'b0;
            dac_wrt_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en_i) begin
                        state <= START;
                    end
                end
                START: begin
                    if (!en_i) begin
                        state <= IDLE;
                    end else if (lvl_ok) begin
                        state     <= RUN;
                        phase     <= 1'b0;
                        hold_a    <= wa;
                        hold_b    <= wb;
                        dac_dat_o <= wa;
                        dac_sel_o <= 1'b1;
                        dac_wrt_o <= 1'b0;
                    end
                end
                RUN, UNDER: begin
                    if (!en_i) begin
                        stop_req <= 1'b1;
                    end
                    if (!phase) begin
                        phase     <= 1'b1;
                        dac_dat_o <= hold_b;
                        dac_sel_o <= 1'b0;
                        dac_wrt_o <= 1'b1;
                    end else if (stop) begin
                        state     <= IDLE;
                        phase     <= 1'b0;
                        stop_req  <= 1'b0;
                        dac_dat_o <= MID;
                        dac_sel_o <= 1'b0;
                        dac_wrt_o <= 1'b0;
                    end else if (!empty) begin
                        state     <= RUN;
                        phase     <= 1'b0;
                        hold_a    <= wa;
                        hold_b    <= wb;
                        dac_dat_o <= wa;
                        dac_sel_o <= 1'b1;
                        dac_wrt_o <= 1'b0;
                    end else begin
                        state     <= UNDER;
                        phase     <= 1'b0;
                        dac_dat_o <= hold_a;
                        dac_sel_o <= 1'b1;
                        dac_wrt_o <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A new underrun beats a same-cycle clear, so the count restarts at 1.
    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else if (under_ev) begin
            underrun_o <= 1'b1;
            if (clr_i) begin
                underrun_cnt_o <= 16'd1;
            end else if (!(&underrun_cnt_o)) begin
                underrun_cnt_o <= underrun_cnt_o + 16'd1;
            end
        end else if (clr_i) begin
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_dac_interleave_tx.sv
// Directed vector bench for dac_interleave_tx: framing, underrun, full, stop, reset.
module tb_dac_interleave_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        ready;
    logic [13:0] dat;
    logic        sel;
    logic        wrt;
    logic        drst;
    logic        un;
    logic [15:0] cnt;
    logic [1:0]  st;
    logic [3:0]  lvl;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dac_interleave_tx dut (
        .dac_clk_i      (clk),
        .dac_rst_i      (rst),
        .en_i           (en),
        .clr_i          (clr),
        .s_dat_a_i      (a),
        .s_dat_b_i      (b),
        .s_valid_i      (valid),
        .s_ready_o      (ready),
        .dac_dat_o      (dat),
        .dac_sel_o      (sel),
        .dac_wrt_o      (wrt),
        .dac_rst_o      (drst),
        .underrun_o     (un),
        .underrun_cnt_o (cnt),
        .state_o        (st),
        .fifo_lvl_o     (lvl)
    );

    typedef struct {
        bit en;
        bit val;
        bit clr;
        int a;
        int b;
        int dat;
        bit sel;
        bit wrt;
        int st;
        int lvl;
        bit un;
        int cnt;
    } vec_t;

    vec_t tv[25];
    int   pa[9];
    int   pb[9];

    function automatic vec_t mk(bit e, bit v, int sa, int sb, bit c,
                                int d, bit s, bit w, int t, int l,
                                bit u, int n);
        vec_t r;
        r.en = e; r.val = v; r.a = sa; r.b = sb; r.clr = c;
        r.dat = d; r.sel = s; r.wrt = w; r.st = t; r.lvl = l;
        r.un = u; r.cnt = n;
        return r;
    endfunction

    function automatic int conv(int x);
        int s;
        s = (x > 8191) ? 8191 : ((x < -8192) ? -8192 : x);
        return s + 8192;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " dat"}, 32'(dat), 32'h2000);
        chk({tag, " sel"}, 32'(sel), 0);
        chk({tag, " wrt"}, 32'(wrt), 0);
        chk({tag, " dac_rst"}, 32'(drst), 1);
        chk({tag, " ready"}, 32'(ready), 0);
        chk({tag, " underrun"}, 32'(un), 0);
        chk({tag, " cnt"}, 32'(cnt), 0);
        chk({tag, " state"}, 32'(st), 0);
        chk({tag, " lvl"}, 32'(lvl), 0);
    endtask

    initial begin
        int  n;
        bit  take;
        string nm;

        tv[0]  = mk(1, 1, 0, -8192, 0, 'h2000, 0, 0, 1, 1, 0, 0);
        tv[1]  = mk(1, 1, 8191, 20000, 0, 'h2000, 0, 0, 1, 2, 0, 0);
        tv[2]  = mk(1, 1, -30000, 1, 0, 'h2000, 0, 0, 1, 3, 0, 0);
        tv[3]  = mk(1, 1, 100, -100, 0, 'h2000, 0, 0, 1, 4, 0, 0);
        tv[4]  = mk(1, 0, 0, 0, 0, 'h2000, 1, 0, 2, 3, 0, 0);
        tv[5]  = mk(1, 0, 0, 0, 0, 'h0000, 0, 1, 2, 3, 0, 0);
        tv[6]  = mk(1, 0, 0, 0, 0, 'h3FFF, 1, 0, 2, 2, 0, 0);
        tv[7]  = mk(1, 0, 0, 0, 0, 'h3FFF, 0, 1, 2, 2, 0, 0);
        tv[8]  = mk(1, 0, 0, 0, 0, 'h0000, 1, 0, 2, 1, 0, 0);
        tv[9]  = mk(1, 0, 0, 0, 0, 'h2001, 0, 1, 2, 1, 0, 0);
        tv[10] = mk(1, 0, 0, 0, 0, 'h2064, 1, 0, 2, 0, 0, 0);
        tv[11] = mk(1, 0, 0, 0, 0, 'h1F9C, 0, 1, 2, 0, 0, 0);
        tv[12] = mk(1, 0, 0, 0, 0, 'h2064, 1, 0, 3, 0, 1, 1);
        tv[13] = mk(1, 0, 0, 0, 0, 'h1F9C, 0, 1, 3, 0, 1, 1);
        tv[14] = mk(1, 0, 0, 0, 0, 'h2064, 1, 0, 3, 0, 1, 2);
        tv[15] = mk(1, 1, 1000, -1000, 0, 'h1F9C, 0, 1, 3, 1, 1, 2);
        tv[16] = mk(1, 0, 0, 0, 0, 'h23E8, 1, 0, 2, 0, 1, 2);
        tv[17] = mk(1, 0, 0, 0, 0, 'h1C18, 0, 1, 2, 0, 1, 2);
        tv[18] = mk(1, 0, 0, 0, 0, 'h23E8, 1, 0, 3, 0, 1, 3);
        tv[19] = mk(1, 0, 0, 0, 0, 'h1C18, 0, 1, 3, 0, 1, 3);
        tv[20] = mk(1, 0, 0, 0, 1, 'h23E8, 1, 0, 3, 0, 1, 1);
        tv[21] = mk(1, 0, 0, 0, 1, 'h1C18, 0, 1, 3, 0, 0, 0);
        tv[22] = mk(1, 0, 0, 0, 0, 'h23E8, 1, 0, 3, 0, 1, 1);
        tv[23] = mk(0, 1, 5, 5, 0, 'h1C18, 0, 1, 3, 1, 1, 1);
        tv[24] = mk(0, 0, 0, 0, 0, 'h2000, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 9; i++) begin
            pa[i] = i * 2000 - 7000;
            pb[i] = 9000 - i * 2500;
        end
        pa[8] = 1234;
        pb[8] = -1234;

        // Reset and DAC reset sequencing
        repeat (3) tick();
        chk_reset_vals("in_reset");
        rst = 1'b0;
        n = 0;
        while (drst && n < 100) begin
            tick();
            n++;
        end
        chk("dac_rst_len", 32'(n), 16);
        chk("ready_after_rst", 32'(ready), 1);
        chk("mid_after_rst", 32'(dat), 32'h2000);

        // Main stream, underrun replay, clear race, stop mid-frame
        for (int i = 0; i < 25; i++) begin
            en    = tv[i].en;
            valid = tv[i].val;
            a     = 16'(tv[i].a);
            b     = 16'(tv[i].b);
            clr   = tv[i].clr;
            tick();
            nm = $sformatf("v%0d", i);
            chk({nm, " dat"}, 32'(dat), 32'(tv[i].dat));
            chk({nm, " sel"}, 32'(sel), 32'(tv[i].sel));
            chk({nm, " wrt"}, 32'(wrt), 32'(tv[i].wrt));
            chk({nm, " state"}, 32'(st), 32'(tv[i].st));
            chk({nm, " lvl"}, 32'(lvl), 32'(tv[i].lvl));
            chk({nm, " underrun"}, 32'(un), 32'(tv[i].un));
            chk({nm, " cnt"}, 32'(cnt), 32'(tv[i].cnt));
        end
        clr = 1'b0;

        // Fill to full in IDLE, stall extra pair, then drain in order
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            a = 16'(pa[i]);
            b = 16'(pb[i]);
            tick();
        end
        chk("full lvl", 32'(lvl), 8);
        chk("full ready", 32'(ready), 0);
        a = 16'(pa[8]);
        b = 16'(pb[8]);
        repeat (3) tick();
        chk("stall lvl", 32'(lvl), 8);
        chk("stall ready", 32'(ready), 0);
        chk("stall state", 32'(st), 0);
        en = 1'b1;
        tick();
        chk("drain start state", 32'(st), 1);
        tick();
        chk("pop while full lvl", 32'(lvl), 7);
        for (int k = 0; k < 18; k++) begin
            nm = $sformatf("drain w%0d", k);
            if (k % 2 == 0) begin
                chk({nm, " dat"}, 32'(dat), 32'(conv(pa[k / 2])));
                chk({nm, " sel"}, 32'(sel), 1);
                chk({nm, " wrt"}, 32'(wrt), 0);
            end else begin
                chk({nm, " dat"}, 32'(dat), 32'(conv(pb[k / 2])));
                chk({nm, " sel"}, 32'(sel), 0);
                chk({nm, " wrt"}, 32'(wrt), 1);
            end
            chk({nm, " state"}, 32'(st), 2);
            if (k == 16) begin
                en = 1'b0;
            end
            take = valid && ready;
            tick();
            if (take) begin
                valid = 1'b0;
            end
        end
        chk("drain end dat", 32'(dat), 32'h2000);
        chk("drain end wrt", 32'(wrt), 0);
        chk("drain end state", 32'(st), 0);
        chk("drain end lvl", 32'(lvl), 0);
        chk("drain end valid taken", 32'(valid), 0);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            a = 16'(i * 10);
            b = 16'(-i * 10);
            tick();
        end
        valid = 1'b0;
        en = 1'b1;
        tick();
        tick();
        chk("pre_rst state", 32'(st), 2);
        chk("pre_rst sel", 32'(sel), 1);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
